// File: rtl/fifo_pkg.sv
// Shared FIFO constants, pointer type and wrap-aware pointer increment.
package fifo_pkg;

  localparam int unsigned S        = 12;
  localparam int unsigned DEPTH    = 150;
  localparam int unsigned AE_LEVEL = 4;
  localparam int unsigned IDX_W    = S - 1;

  // Wrap bit distinguishes full from empty when indices match.
  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } ptr_t;

  // Index counts 0..DEPTH-1, then returns to 0 and toggles the wrap bit.
  function automatic ptr_t ptr_next(ptr_t p);
    ptr_t n;
    if (p.idx == IDX_W'(DEPTH - 1)) begin
      n.idx  = '0;
      n.wrap = ~p.wrap;
    end else begin
      n.idx  = p.idx + 1'b1;
      n.wrap = p.wrap;
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_read_unit_if.sv
// Read-side bus: requests and writer pointer in, pointer and status out.
interface fifo_read_unit_if;
  import fifo_pkg::*;

  logic             rd_en;
  ptr_t             wr_ptr;
  logic             clr_underflow;
  ptr_t             rd_ptr;
  logic [IDX_W-1:0] rd_addr;
  logic             o_fifo_empty;
  logic             o_almost_empty;
  logic [S-1:0]     o_count;
  logic             o_rd_valid;
  logic             o_underflow;

  modport master (
    output rd_en, wr_ptr, clr_underflow,
    input  rd_ptr, rd_addr, o_fifo_empty, o_almost_empty, o_count, o_rd_valid, o_underflow
  );

  modport slave (
    input  rd_en, wr_ptr, clr_underflow,
    output rd_ptr, rd_addr, o_fifo_empty, o_almost_empty, o_count, o_rd_valid, o_underflow
  );

endinterface

// File: rtl/fifo_ptr_occupancy.sv
// Occupancy between a leading (write) and trailing (read) pointer.
module fifo_ptr_occupancy
  import fifo_pkg::*;
(
  input  ptr_t         wr_ptr,
  input  ptr_t         rd_ptr,
  output logic [S-1:0] count
);

  // Same lap: plain difference; different lap: writer has wrapped past the end.
  always_comb begin
    if (wr_ptr.wrap == rd_ptr.wrap) begin
      count = {1'b0, wr_ptr.idx} - {1'b0, rd_ptr.idx};
    end else begin
      count = S'(DEPTH) - {1'b0, rd_ptr.idx} + {1'b0, wr_ptr.idx};
    end
  end

endmodule

// File: rtl/fifo_read_unit.sv
// Read-side pointer and status controller; single-clock, writer pointer used directly.
module fifo_read_unit
  import fifo_pkg::*;
(
  input logic             wr_clk,
  input logic             wr_rst,
  fifo_read_unit_if.slave bus
);

  ptr_t         rd_ptr_q, rd_ptr_d;
  logic         rd_valid_q;
  logic         underflow_q, underflow_d;
  logic         empty;
  logic         acc;
  logic [S-1:0] count;

  fifo_ptr_occupancy u_occ (
    .wr_ptr (bus.wr_ptr),
    .rd_ptr (rd_ptr_q),
    .count  (count)
  );

  // Accept decision, next pointer and sticky underflow (set beats clear).
  always_comb begin
    empty       = (rd_ptr_q == bus.wr_ptr);
    acc         = bus.rd_en & ~empty;
    rd_ptr_d    = acc ? ptr_next(rd_ptr_q) : rd_ptr_q;
    underflow_d = underflow_q;
    if (bus.rd_en & empty) begin
      underflow_d = 1'b1;
    end else if (bus.clr_underflow) begin
      underflow_d = 1'b0;
    end
  end

  // State registers; async reset also drops an in-flight read-valid.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      rd_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_valid_q  <= acc;
      underflow_q <= underflow_d;
    end
  end

  assign bus.rd_ptr         = rd_ptr_q;
  assign bus.rd_addr        = rd_ptr_q.idx;
  assign bus.o_fifo_empty   = empty;
  assign bus.o_count        = count;
  assign bus.o_almost_empty = (count <= S'(AE_LEVEL));
  assign bus.o_rd_valid     = rd_valid_q;
  assign bus.o_underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_read_unit.sv
// Self-checking bench: positional model of the read side plus directed literal checks.
module tb_fifo_read_unit;
  import fifo_pkg::*;

  localparam int TwoD = 2 * int'(DEPTH);

  logic wr_clk = 1'b0;
  logic wr_rst = 1'b1;

  fifo_read_unit_if bus ();

  fifo_read_unit dut (
    .wr_clk (wr_clk),
    .wr_rst (wr_rst),
    .bus    (bus.slave)
  );

  always #5 wr_clk = ~wr_clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   wpos     = 0;  // writer position 0..2*DEPTH-1
  int   m_rpos;        // model reader position 0..2*DEPTH-1
  logic m_valid;
  logic m_uflow;

  // Position on a 2*DEPTH ring -> pointer encoding.
  function automatic int enc(int pos);
    return ((pos >= int'(DEPTH)) ? (1 << (S - 1)) : 0) + (pos % int'(DEPTH));
  endfunction

  function automatic int dec(int p);
    return ((p >> (S - 1)) & 1) * int'(DEPTH) + (p % (1 << (S - 1)));
  endfunction

  function automatic int occ();
    return (dec(int'(bus.wr_ptr)) - m_rpos + TwoD) % TwoD;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
  endtask

  task automatic step();
    @(posedge wr_clk);
    #1;
  endtask

  task automatic setw(input int p);
    wpos       = p;
    bus.wr_ptr = ptr_t'(enc(p));
  endtask

  task automatic do_reset();
    wr_rst            = 1'b1;
    bus.rd_en         = 1'b0;
    bus.clr_underflow = 1'b0;
    setw(0);
    step();
    step();
    wr_rst = 1'b0;
  endtask

  // Reference model: reader position on a ring of 2*DEPTH slots.
  always @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      m_rpos  <= 0;
      m_valid <= 1'b0;
      m_uflow <= 1'b0;
    end else begin
      m_valid <= bus.rd_en && (occ() != 0);
      if (bus.rd_en && occ() != 0) m_rpos <= (m_rpos + 1) % TwoD;
      if (bus.rd_en && occ() == 0) m_uflow <= 1'b1;
      else if (bus.clr_underflow) m_uflow <= 1'b0;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge wr_clk) begin
    int c;
    c = occ();
    chk("rd_ptr", int'(bus.rd_ptr), enc(m_rpos));
    chk("rd_addr", int'(bus.rd_addr), m_rpos % int'(DEPTH));
    chk("empty", int'(bus.o_fifo_empty), int'(c == 0));
    chk("count", int'(bus.o_count), c);
    chk("almost_empty", int'(bus.o_almost_empty), int'(c <= int'(AE_LEVEL)));
    chk("rd_valid", int'(bus.o_rd_valid), int'(m_valid));
    chk("underflow", int'(bus.o_underflow), int'(m_uflow));
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_pct, rd_pct;
    bus.rd_en         = 1'b0;
    bus.clr_underflow = 1'b0;
    setw(0);
    do_reset();

    // Reset state
    @(negedge wr_clk); #1;
    chk("t1_rd_ptr", int'(bus.rd_ptr), 0);
    chk("t1_empty", int'(bus.o_fifo_empty), 1);
    chk("t1_count", int'(bus.o_count), 0);
    chk("t1_ae", int'(bus.o_almost_empty), 1);
    chk("t1_valid", int'(bus.o_rd_valid), 0);
    chk("t1_uflow", int'(bus.o_underflow), 0);
    chk("t1_rd_addr", int'(bus.rd_addr), 0);

    // Five back-to-back reads
    setw(5);
    bus.rd_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_rd_addr", int'(bus.rd_addr), k);
      chk("t2_count", int'(bus.o_count), 5 - k);
      chk("t2_ae", int'(bus.o_almost_empty), int'(5 - k <= 4));
      step();
      chk("t2_valid", int'(bus.o_rd_valid), 1);
    end
    chk("t2_empty", int'(bus.o_fifo_empty), 1);
    chk("t2_count_end", int'(bus.o_count), 0);
    bus.rd_en = 1'b0;
    step();
    chk("t2_valid_off", int'(bus.o_rd_valid), 0);
    chk("t2_uflow", int'(bus.o_underflow), 0);

    // Wrap of index 149 -> 0 with wrap toggle
    do_reset();
    setw(149);
    bus.rd_en = 1'b1;
    repeat (149) step();
    bus.rd_en = 1'b0;
    chk("t3_rd_ptr", int'(bus.rd_ptr), 'h095);
    setw(dec('h802));
    #1;
    chk("t3_count", int'(bus.o_count), 3);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("t3_rd_ptr_wrap", int'(bus.rd_ptr), 'h800);
    chk("t3_count_after", int'(bus.o_count), 2);

    // Full as seen by the reader
    do_reset();
    setw(dec('h800));
    #1;
    chk("t4_count", int'(bus.o_count), 150);
    chk("t4_empty", int'(bus.o_fifo_empty), 0);
    chk("t4_ae", int'(bus.o_almost_empty), 0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("t4_rd_ptr", int'(bus.rd_ptr), 'h001);
    chk("t4_count_after", int'(bus.o_count), 149);

    // Underflow set / hold / set-beats-clear / clear
    do_reset();
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("t5_rd_ptr", int'(bus.rd_ptr), 0);
    chk("t5_valid", int'(bus.o_rd_valid), 0);
    chk("t5_uflow_set", int'(bus.o_underflow), 1);
    step();
    chk("t5_uflow_hold", int'(bus.o_underflow), 1);
    bus.rd_en         = 1'b1;
    bus.clr_underflow = 1'b1;
    step();
    bus.rd_en = 1'b0;
    chk("t5_uflow_set_wins", int'(bus.o_underflow), 1);
    step();
    bus.clr_underflow = 1'b0;
    chk("t5_uflow_clr", int'(bus.o_underflow), 0);

    // Asynchronous reset mid-burst
    do_reset();
    setw(10);
    bus.rd_en = 1'b1;
    repeat (3) step();
    chk("t6_pre_valid", int'(bus.o_rd_valid), 1);
    #2;
    wr_rst = 1'b1;
    #1;
    chk("t6_rst_rd_ptr", int'(bus.rd_ptr), 0);
    chk("t6_rst_valid", int'(bus.o_rd_valid), 0);
    step();
    wr_rst = 1'b0;
    chk("t6_rd_addr", int'(bus.rd_addr), 0);
    step();
    chk("t6_resume_ptr", int'(bus.rd_ptr), 1);
    chk("t6_resume_valid", int'(bus.o_rd_valid), 1);
    bus.rd_en = 1'b0;

    // Random traffic: alternating fill-heavy and drain-heavy phases
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      wr_pct = ((i / 300) % 2 == 0) ? 90 : 30;
      rd_pct = ((i / 300) % 2 == 0) ? 35 : 85;
      bus.rd_en         = ($urandom_range(0, 99) < rd_pct);
      bus.clr_underflow = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 99) < wr_pct && occ() < int'(DEPTH)) setw((wpos + 1) % TwoD);
      step();
    end
    bus.rd_en         = 1'b0;
    bus.clr_underflow = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
